// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the instruction-stream encoder: opcodes, op classes
// and the writer FSM state encoding.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] CLS_LOAD   = 3'd0;
  localparam logic [2:0] CLS_STORE  = 3'd1;
  localparam logic [2:0] CLS_OPIMM  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_OP     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

endpackage

// File: rtl/rv32i_field_encoder.sv
// Combinational RV32I field packer: op class plus operand fields in, 32-bit
// machine word and an illegal flag out.
module rv32i_field_encoder
  import rv32i_pkg::*;
(
  input  logic [2:0]  op_class,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Shift-immediates carry funct7 in the upper immediate bits; branches need even offsets.
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (op_class)
      CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      CLS_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OPC_OPIMM};
        end else begin
          word = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
        end
      end
      CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      CLS_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        illegal = imm[0];
      end
      CLS_OP:     word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OPC_OP};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Accepts RV32I field bundles over valid/ready and writes the encoded words
// sequentially into instruction memory, one word every two cycles.
module instr_stream_encoder
  import rv32i_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op_class,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [12:0] in_imm,
  input  logic        in_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        err_illegal
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  enc_state_e  state, state_nxt;
  logic [31:0] ptr, addr_q, wdata_q, enc_word;
  logic [15:0] cnt;
  logic        last_q, err_q, enc_illegal, at_limit;

  rv32i_field_encoder u_enc (
    .op_class (in_op_class),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .imm      (in_imm),
    .word     (enc_word),
    .illegal  (enc_illegal)
  );

  assign at_limit = (({1'b0, cnt} + 17'd1) >= DEPTH_W);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (in_valid) begin
          if (enc_illegal) state_nxt = in_last ? ST_DONE : ST_RUN;
          else             state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: state_nxt = (last_q || at_limit) ? ST_DONE : ST_RUN;
      ST_DONE:  if (start) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, pointer, counter and write-port holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= BASE_ADDR;
      cnt     <= 16'd0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'h0000_0000;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            ptr   <= BASE_ADDR;
            cnt   <= 16'd0;
            err_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            if (enc_illegal) begin
              err_q <= 1'b1;
            end else begin
              addr_q  <= ptr;
              wdata_q <= enc_word;
              last_q  <= in_last;
            end
          end
        end
        ST_WRITE: begin
          if ({1'b0, cnt} < DEPTH_W) begin
            ptr <= ptr + 32'd4;
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset forces every output to its idle value in the same cycle, which also kills a write in flight.
  always_comb begin
    in_ready    = 1'b0;
    imem_we     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err_illegal = 1'b0;
    imem_addr   = BASE_ADDR;
    imem_wdata  = 32'h0000_0000;
    count       = 16'd0;
    if (!rst) begin
      in_ready    = (state == ST_RUN);
      imem_we     = (state == ST_WRITE);
      busy        = (state == ST_RUN) || (state == ST_WRITE);
      done        = (state == ST_DONE);
      err_illegal = err_q;
      imem_addr   = addr_q;
      imem_wdata  = wdata_q;
      count       = cnt;
    end
  end

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Writer-side counterpart of the control decoder: accepts RV32I instruction fields over a valid/ready handshake and encodes them into 32-bit machine words.
- Writes the words sequentially into instruction memory through a simple write port.
- Used by the test/boot loader to build programs in imem before the core runs.
- Encodes exactly the opcode set the core decodes: load, store, OP-IMM, branch, R-type.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after start.
- DEPTH, 64, maximum words per program (1..65535).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  pulse: clear pointer/count/errors, enter RUN (honoured only in IDLE or DONE)
- in_valid  input  1  field bundle valid
- in_ready  output  1  block can accept a bundle
- in_op_class  input  3  0=LOAD 1=STORE 2=OPIMM 3=BRANCH 4=OP; 5-7 illegal
- in_rd  input  5  destination register
- in_rs1  input  5  source 1
- in_rs2  input  5  source 2
- in_funct3  input  3  funct3, passed through
- in_funct7b5  input  1  instr[30] (sub/sra/srai)
- in_imm  input  13  signed immediate; bits used per format
- in_last  input  1  final instruction of the program
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  32  byte address of the write
- imem_wdata  output  32  encoded word
- count  output  16  words written since start
- busy  output  1  high in RUN or WRITE
- done  output  1  high in DONE
- err_illegal  output  1  sticky; an illegal bundle was dropped

Behaviour:
- Reset is synchronous and active-high, and has priority over everything. While rst is high: state=IDLE; in_ready, imem_we, busy, done and err_illegal are 0; imem_addr=BASE_ADDR; imem_wdata=0; count=0. Reset in WRITE suppresses that write.
- FSM states: IDLE, RUN, WRITE, DONE.
  - IDLE: in_ready=0. start -> RUN, with pointer=BASE_ADDR, count=0, err_illegal=0.
  - RUN: in_ready=1. A handshake (in_valid && in_ready) registers the encoded word and in_last.
    - Legal bundle -> WRITE.
    - Illegal bundle (op_class 5-7, or BRANCH with in_imm[0]=1): no write; err_illegal<=1; go to DONE if in_last, else stay in RUN.
  - WRITE: in_ready=0; imem_we=1 for exactly one cycle with imem_addr=pointer and imem_wdata=word. Next edge: pointer+=4; count+=1. Go to DONE if last or if count+1==DEPTH, else RUN.
  - DONE: in_ready=0, done=1. start -> RUN (restart as from IDLE).
- start is ignored in RUN and WRITE.
- Throughput: one word per 2 cycles. Latency from handshake edge to imem_we high is 1 cycle.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Encodings, by op_class:
  - LOAD (opcode 0000011) and OPIMM (opcode 0010011), I-type: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
  - OPIMM exception for funct3 001/101: [31:25]={1'b0,funct7b5,5'b0}, [24:20]=imm[4:0].
  - STORE (opcode 0100011), S-type: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
  - BRANCH (opcode 1100011), B-type: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11].
  - OP (opcode 0110011), R-type: [31:25]={1'b0,funct7b5,5'b0}, [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
- Unused input fields for a format are ignored. in_imm[12] is used only by BRANCH.
- count saturates at DEPTH, never wraps, and no write occurs once DEPTH is reached.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_BRANCH, OPC_OP (matching the decoder);
  - op_class constants;
  - FSM state encoding.
- One combinational sub-module, rv32i_field_encoder: op_class plus fields -> {word, illegal}. The FSM, pointer and counter stay in the top module.

Test Plan:
- LOAD, rd=5, rs1=2, f3=010, imm=8 -> imem_we at BASE_ADDR, wdata=32'h0081_2283, count=1.
- STORE, rs1=2, rs2=6, f3=010, imm=12 -> wdata=32'h0061_2623 at address BASE_ADDR+4.
- BRANCH, rs1=1, rs2=2, f3=000, imm=-4 -> 32'hFE20_8EE3. Then the same bundle with imm=3 -> no write, err_illegal=1.
- OP, rd=3, rs1=1, rs2=2, f3=000, f7b5=1 -> 32'h4020_81B3. Then OPIMM, rd=1, rs1=0, imm=-1 with in_last=1 -> 32'hFFF0_0093, then done=1, in_ready=0.
- DEPTH=2: offer 3 bundles with in_valid held high -> exactly 2 writes, DONE after the 2nd, the 3rd never handshaken, count=2. Then start -> addr back to BASE_ADDR.
- rst asserted in the WRITE cycle -> imem_we=0 that cycle; next cycle IDLE with all outputs at reset values. start ignored while busy.
